// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the RV32M multiply path.
//   mul_op_e    - multiply operation encoding (matches req_op / mul_op).
//   mul_state_e - sequencer FSM states.
//   FUNCT3_*    - funct3 values used by the decoder for the same operations.
//   select_word - picks the architecturally visible word of a full product.
package mul_pkg;

    // Width the shared helper is built for; mul_sequencer's XLEN must match it.
    localparam int unsigned MUL_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } mul_state_e;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

    // MUL returns the low word; every MULH variant returns the high word.
    function automatic logic [MUL_XLEN-1:0] select_word(
        input mul_op_e               op,
        input logic [2*MUL_XLEN-1:0] product
    );
        return (op == OP_MUL) ? product[MUL_XLEN-1:0] : product[2*MUL_XLEN-1:MUL_XLEN];
    endfunction

endpackage

// File: rtl/mul_result_cache.sv
// mul_result_cache: single-entry cache of the last completed multiplier product.
//   clk, reset            - clock, synchronous active-high reset (invalidates).
//   load                  - capture ld_rs1/ld_rs2/ld_op/ld_prod and mark valid.
//   invalidate            - drop the entry (wins over load).
//   lk_rs1/lk_rs2/lk_op   - lookup tag of the incoming request.
//   hit                   - lookup matches the stored entry.
//   prod                  - stored full product.
module mul_result_cache
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              invalidate,
    input  logic [XLEN-1:0]   ld_rs1,
    input  logic [XLEN-1:0]   ld_rs2,
    input  mul_op_e           ld_op,
    input  logic [2*XLEN-1:0] ld_prod,
    input  logic [XLEN-1:0]   lk_rs1,
    input  logic [XLEN-1:0]   lk_rs2,
    input  mul_op_e           lk_op,
    output logic              hit,
    output logic [2*XLEN-1:0] prod
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    mul_op_e           op_q, op_d;
    logic [2*XLEN-1:0] prod_q, prod_d;

    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        op_d    = op_q;
        prod_d  = prod_q;
        if (invalidate) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            rs1_d   = ld_rs1;
            rs2_d   = ld_rs2;
            op_d    = ld_op;
            prod_d  = ld_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_q    <= OP_MUL;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
        end
    end

    // The low product word is signedness-independent, so MUL may reuse any op.
    assign hit  = valid_q && (lk_rs1 == rs1_q) && (lk_rs2 == rs2_q) &&
                  ((lk_op == OP_MUL) || (lk_op == op_q));
    assign prod = prod_q;

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: issue/response controller between execute and the multi-cycle
// multiplier. Accepts one request, answers zero operands and repeated operands
// from the last product directly, otherwise starts the multiplier and waits for
// done or a watchdog timeout.
//   req_*   - request handshake (op, operands, destination tag).
//   resp_*  - response handshake (selected word, echoed tag, timeout flag).
//   mul_*   - multiplier interface: latched operands/op, start pulse, done, product.
//   idle    - no request in flight and no response pending.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned XLEN           = MUL_XLEN,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic [XLEN-1:0]   mul_rs1,
    output logic [XLEN-1:0]   mul_rs2,
    output logic [1:0]        mul_op,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [2*XLEN-1:0] mul_product,
    output logic              idle
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    mul_state_e        state_q, state_d;
    mul_op_e           op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    mul_op_e           req_op_e;
    logic              cache_hit;
    logic              cache_load;
    logic              cache_inval;
    logic [2*XLEN-1:0] cache_prod;

    assign req_op_e = mul_op_e'(req_op);

    mul_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .clk        (clk),
        .reset      (reset),
        .load       (cache_load),
        .invalidate (cache_inval),
        .ld_rs1     (rs1_q),
        .ld_rs2     (rs2_q),
        .ld_op      (op_q),
        .ld_prod    (mul_product),
        .lk_rs1     (req_rs1),
        .lk_rs2     (req_rs2),
        .lk_op      (req_op_e),
        .hit        (cache_hit),
        .prod       (cache_prod)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        cache_load  = 1'b0;
        cache_inval = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op_e;
                    rs1_d = req_rs1;
                    rs2_d = req_rs2;
                    rd_d  = req_rd;
                    err_d = 1'b0;
                    // Zero operand beats the cache; the multiplier stays idle.
                    if ((req_rs1 == '0) || (req_rs2 == '0)) begin
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else if (cache_hit) begin
                        data_d  = select_word(req_op_e, cache_prod);
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // done takes priority over a coincident timeout.
                if (mul_done) begin
                    data_d     = select_word(op_q, mul_product);
                    err_d      = 1'b0;
                    cache_load = 1'b1;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    data_d      = '0;
                    err_d       = 1'b1;
                    cache_inval = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign mul_start  = (state_q == ST_ISSUE);
    assign idle       = req_ready && !resp_valid;
    assign resp_data  = data_q;
    assign resp_rd    = rd_q;
    assign resp_err   = err_q;
    assign mul_rs1    = rs1_q;
    assign mul_rs2    = rs2_q;
    assign mul_op     = op_q;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    localparam int TO = 24;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [31:0] mul_rs1;
    logic [31:0] mul_rs2;
    logic [1:0]  mul_op;
    logic        mul_start;
    logic        mul_done;
    logic [63:0] mul_product;
    logic        idle;

    mul_sequencer #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_rd     (resp_rd),
        .resp_err    (resp_err),
        .mul_rs1     (mul_rs1),
        .mul_rs2     (mul_rs2),
        .mul_op      (mul_op),
        .mul_start   (mul_start),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full 64-bit product from RV32M signedness rules, computed modulo 2^64.
    function automatic logic [63:0] full_product(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = (op == 2'd3) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (op <= 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] word_of(input logic [1:0] op, input logic [63:0] p);
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier model: done arrives mul_lat cycles after the start pulse; 0 = never.
    int  start_count = 0;
    int  mul_lat     = 0;
    bit  stray       = 1'b0;
    initial begin
        bit          pending;
        int          cnt;
        logic [1:0]  cop;
        logic [31:0] ca, cb;
        pending     = 1'b0;
        cnt         = 0;
        cop         = '0;
        ca          = '0;
        cb          = '0;
        mul_done    = 1'b0;
        mul_product = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        mul_done    = 1'b1;
                        mul_product = full_product(cop, ca, cb);
                        pending     = 1'b0;
                    end
                end
                if (mul_start) begin
                    start_count++;
                    if (mul_lat > 0) begin
                        pending = 1'b1;
                        cnt     = mul_lat;
                        cop     = mul_op;
                        ca      = mul_rs1;
                        cb      = mul_rs2;
                    end
                end
                if (stray) begin
                    mul_done    = 1'b1;
                    mul_product = {$urandom, $urandom};
                    stray       = 1'b0;
                end
            end
        end
    end

    // Reference model: last successful product, zero shortcut, timeout invalidation.
    bit          rv = 1'b0;
    logic [31:0] rc_a, rc_b;
    logic [1:0]  rc_op;
    logic [63:0] rc_prod;

    task automatic predict(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int lat,
                           output logic [31:0] ed, output bit ee, output int es, output int el);
        logic [63:0] p;
        ee = 1'b0;
        if (a == 0 || b == 0) begin
            ed = '0; es = 0; el = 1;
        end else if (rv && a == rc_a && b == rc_b && (op == 2'd0 || op == rc_op)) begin
            ed = word_of(op, rc_prod); es = 0; el = 1;
        end else begin
            es = 1;
            if (lat >= 1 && lat <= TO) begin
                p = full_product(op, a, b);
                ed = word_of(op, p); el = lat + 2;
                rv = 1'b1; rc_a = a; rc_b = b; rc_op = op; rc_prod = p;
            end else begin
                ed = '0; ee = 1'b1; el = TO + 2; rv = 1'b0;
            end
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_req", req_ready, 1);
    endtask

    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input int lat, input int hold,
                           output logic [31:0] d, output bit e, output logic [4:0] r, output int ns, output int lt);
        int s0;
        wait_ready();
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        mul_lat = lat;
        s0 = start_count;
        @(negedge clk);
        req_valid = 1'b0; req_rs1 = $urandom; req_rs2 = $urandom; req_rd = 5'($urandom);
        lt = 1;
        while (!resp_valid && lt < 200) begin
            check("mul_rs1_stable", mul_rs1, a);
            check("mul_rs2_stable", mul_rs2, b);
            check("mul_op_stable", mul_op, op);
            @(negedge clk);
            lt++;
        end
        check("resp_valid_seen", resp_valid, 1);
        d = resp_data; e = resp_err; r = resp_rd;
        for (int i = 0; i < hold; i++) begin
            if (i == 1 && hold >= 3) stray = 1'b1;
            @(negedge clk);
            check("hold_data", resp_data, d);
            check("hold_rd", resp_rd, r);
            check("hold_err", resp_err, e);
            check("hold_valid", resp_valid, 1);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_after_resp", idle, 1);
        check("err_cleared", resp_err, 0);
        ns = start_count - s0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold;
        logic [31:0] ed;
        bit          ee;
        int          es;
        int          el;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] d, ed, a, b;
        logic [4:0]  r, rd;
        logic [1:0]  op;
        bit          e, ee;
        int          ns, lt, es, el, lat, hold;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_rd", resp_rd, 0);
        check("rst_mul_rs1", mul_rs1, 0);
        check("rst_mul_rs2", mul_rs2, 0);
        check("rst_mul_op", mul_op, 0);
        check("rst_idle", idle, 1);
        reset = 1'b0;
        @(negedge clk);

        //          op     a             b             lat hold ed            ee  es el
        tbl[0]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 18, 0, 32'hFFFFFFFE, 1'b0, 1, 20};
        tbl[1]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 18, 0, 32'h00000001, 1'b0, 0, 1};
        tbl[2]  = '{2'd1, 32'h12345678, 32'h00000000, 4,  0, 32'h00000000, 1'b0, 0, 1};
        tbl[3]  = '{2'd1, 32'h12345678, 32'h00000010, 4,  0, 32'h00000001, 1'b0, 1, 6};
        tbl[4]  = '{2'd1, 32'h12345678, 32'h00000010, 4,  0, 32'h00000001, 1'b0, 0, 1};
        tbl[5]  = '{2'd2, 32'h12345678, 32'h00000010, 4,  0, 32'h00000001, 1'b0, 1, 6};
        tbl[6]  = '{2'd0, 32'h00000003, 32'h00000005, 0,  0, 32'h00000000, 1'b1, 1, TO + 2};
        tbl[7]  = '{2'd0, 32'h00000003, 32'h00000005, 2,  0, 32'h0000000F, 1'b0, 1, 4};
        tbl[8]  = '{2'd1, 32'h80000000, 32'h80000000, 3,  5, 32'h40000000, 1'b0, 1, 5};
        tbl[9]  = '{2'd1, 32'h80000000, 32'h80000000, 3,  0, 32'h40000000, 1'b0, 0, 1};
        tbl[10] = '{2'd2, 32'hFFFFFFFF, 32'h00000002, TO, 0, 32'hFFFFFFFF, 1'b0, 1, TO + 2};
        tbl[11] = '{2'd3, 32'h00000007, 32'h00000009, TO + 1, 0, 32'h00000000, 1'b1, 1, TO + 2};

        for (int i = 0; i < 12; i++) begin
            rd = 5'(i + 1);
            predict(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, ed, ee, es, el);
            run_req(tbl[i].op, tbl[i].a, tbl[i].b, rd, tbl[i].lat, tbl[i].hold, d, e, r, ns, lt);
            check("tbl_data", d, tbl[i].ed);
            check("tbl_err", e, tbl[i].ee);
            check("tbl_rd", r, rd);
            check("tbl_starts", ns, tbl[i].es);
            check("tbl_latency", lt, tbl[i].el);
        end

        // Reset while waiting on the multiplier drops the request and the cache.
        predict(2'd0, 32'd11, 32'd13, 2, ed, ee, es, el);
        run_req(2'd0, 32'd11, 32'd13, 5'd20, 2, 0, d, e, r, ns, lt);
        check("pre_rst_data", d, 32'd143);
        wait_ready();
        req_valid = 1'b1; req_op = 2'd1; req_rs1 = 32'd11; req_rs2 = 32'd13; req_rd = 5'd21;
        mul_lat = 0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("wait_req_ready", req_ready, 0);
        check("wait_resp_valid", resp_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_mul_start", mul_start, 0);
        check("midrst_idle", idle, 1);
        reset = 1'b0;
        rv = 1'b0;
        @(negedge clk);
        predict(2'd0, 32'd11, 32'd13, 2, ed, ee, es, el);
        run_req(2'd0, 32'd11, 32'd13, 5'd22, 2, 0, d, e, r, ns, lt);
        check("postrst_starts", ns, 1);
        check("postrst_data", d, 32'd143);
        check("postrst_latency", lt, 4);

        // Randomized traffic against the reference model.
        a = 32'h1; b = 32'h1;
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 5))
                    0: a = 32'h0;
                    1: a = 32'h1;
                    2: a = 32'hFFFFFFFF;
                    3: a = 32'h80000000;
                    default: a = $urandom;
                endcase
                case ($urandom_range(0, 5))
                    0: b = 32'h0;
                    1: b = 32'h1;
                    2: b = 32'hFFFFFFFF;
                    3: b = 32'h80000000;
                    default: b = $urandom;
                endcase
            end
            lat  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 2));
            hold = $urandom_range(0, 4);
            rd   = 5'($urandom);
            predict(op, a, b, lat, ed, ee, es, el);
            run_req(op, a, b, rd, lat, hold, d, e, r, ns, lt);
            check("rnd_data", d, ed);
            check("rnd_err", e, ee);
            check("rnd_rd", r, rd);
            check("rnd_starts", ns, es);
            check("rnd_latency", lt, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d errors so far, required completion", errors);
        $fatal(1, "time limit");
    end

endmodule
